// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the register file and its scoreboard.
package cpu_types_pkg;

  localparam int RF_NREGS_DEFAULT = 32;
  localparam int WORD_W           = 32;

  typedef logic [WORD_W-1:0]                   word_t;
  typedef logic [$clog2(RF_NREGS_DEFAULT)-1:0] regbits_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking in-flight destinations (WAW hazard detection).
module rf_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS  = RF_NREGS_DEFAULT,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NWRITE-1:0]          wen,
  input  logic [NWRITE-1:0][AW-1:0]  wsel,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_sel,
  output logic                       issue_ok,
  output logic [NREGS-1:0]           busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_hit;

  // issue_en/issue_ok act as valid/ready: an issue is taken only in a cycle
  // where both are high; a stalled requester holds issue_en and retries.
  always_comb begin
    wr_hit = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && (wsel[j] == issue_sel)) wr_hit = 1'b1;
    end
    issue_ok = (issue_sel == '0) || (issue_en && (!busy_q[issue_sel] || wr_hit));
  end

  // Completing writes clear first so a same-cycle accepted issue wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) busy_d[wsel[j]] = 1'b0;
    end
    if (issue_ok && (issue_sel != '0)) busy_d[issue_sel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// Multi-ported register file with a busy-bit scoreboard; register 0 is hardwired to zero.
// Define MULTIPORT_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_register_file
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = $bits(word_t),
  parameter int NREGS  = RF_NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [NREAD-1:0][AW-1:0]      rsel,
  output logic [NREAD-1:0][DATA_W-1:0]  rdat,
  output logic [NREAD-1:0]              rbusy,
  input  logic [NWRITE-1:0]             wen,
  input  logic [NWRITE-1:0][AW-1:0]     wsel,
  input  logic [NWRITE-1:0][DATA_W-1:0] wdat,
  input  logic                          issue_en,
  input  logic [AW-1:0]                 issue_sel,
  output logic                          issue_ok
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (RST),
    .wen       (wen),
    .wsel      (wsel),
    .issue_en  (issue_en),
    .issue_sel (issue_sel),
    .issue_ok  (issue_ok),
    .busy      (busy)
  );

  // Ascending port order lets the highest-indexed writer win a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) regs_d[wsel[j]] = wdat[j];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (RST) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rdat[i]  = regs_q[rsel[i]];
      rbusy[i] = busy[rsel[i]];
`ifdef MULTIPORT_RF_BYPASS_EN
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (wsel[j] == rsel[i]) && (rsel[i] != '0)) begin
          rdat[i]  = wdat[j];
          rbusy[i] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: drivers push expectations tagged with a cycle number, a monitor compares them.
module tb_multiport_register_file;
  import cpu_types_pkg::*;

  localparam int AW = $clog2(RF_NREGS_DEFAULT);

  localparam int K_RDAT0 = 0;
  localparam int K_RDAT1 = 1;
  localparam int K_RBUSY = 2;
  localparam int K_IOK   = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic                clk = 1'b0;
  logic                RST = 1'b1;
  logic [1:0][AW-1:0]  rsel = '0;
  logic [1:0][31:0]    rdat;
  logic [1:0]          rbusy;
  logic [1:0]          wen = '0;
  logic [1:0][AW-1:0]  wsel = '0;
  logic [1:0][31:0]    wdat = '0;
  logic                issue_en = 1'b0;
  logic [AW-1:0]       issue_sel = '0;
  logic                issue_ok;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done = 1'b0;

  multiport_register_file dut (
    .clk       (clk),
    .RST       (RST),
    .rsel      (rsel),
    .rdat      (rdat),
    .rbusy     (rbusy),
    .wen       (wen),
    .wsel      (wsel),
    .wdat      (wdat),
    .issue_en  (issue_en),
    .issue_sel (issue_sel),
    .issue_ok  (issue_ok)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    RST       = 1'b0;
    wen       = '0;
    issue_en  = 1'b0;
    issue_sel = '0;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wen[port]  = 1'b1;
    wsel[port] = AW'(addr);
    wdat[port] = data;
  endtask

  task automatic rd(input int a0, input int a1);
    rsel[0] = AW'(a0);
    rsel[1] = AW'(a1);
  endtask

  task automatic issue(input int addr);
    issue_en  = 1'b1;
    issue_sel = AW'(addr);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      case (e.kind)
        K_RDAT0: act = rdat[0];
        K_RDAT1: act = rdat[1];
        K_RBUSY: act = {30'd0, rbusy};
        default: act = {31'd0, issue_ok};
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    word_t deadbeef;
    deadbeef = 32'hDEADBEEF;

    RST = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    RST = 1'b1;
    step();
    rd(5, 31);
    issue_sel = AW'(3);
    expect_val(K_RDAT0, 32'h0, "reset_rdat0");
    expect_val(K_RDAT1, 32'h0, "reset_rdat1");
    expect_val(K_RBUSY, 32'h0, "reset_rbusy");
    expect_val(K_IOK,   32'h0, "reset_issue_ok_idle");

    // basic write then dual read
    step();
    wr(0, 5, deadbeef);
    rd(5, 5);
`ifdef MULTIPORT_RF_BYPASS_EN
    expect_val(K_RDAT0, deadbeef, "write5_same_cycle");
`else
    expect_val(K_RDAT0, 32'h0, "write5_same_cycle");
`endif
    step();
    rd(5, 5);
    expect_val(K_RDAT0, deadbeef, "read5_port0");
    expect_val(K_RDAT1, deadbeef, "read5_port1");

    // write collision: highest port wins
    step();
    wr(0, 7, 32'h1);
    wr(1, 7, 32'h2);
    step();
    rd(7, 5);
    expect_val(K_RDAT0, 32'h2, "collision_reg7");
    expect_val(K_RDAT1, deadbeef, "reg5_kept");

    // register 0 hardwired
    step();
    wr(0, 0, 32'hFFFFFFFF);
    issue(0);
    rd(0, 0);
    expect_val(K_IOK,   32'h1, "issue_r0_ok");
    expect_val(K_RDAT0, 32'h0, "r0_during_write");
    step();
    rd(0, 0);
    expect_val(K_RDAT0, 32'h0, "r0_after_write");
    expect_val(K_RBUSY, 32'h0, "r0_not_busy");

    // WAW stall and set-wins
    step();
    issue(3);
    rd(3, 0);
    expect_val(K_IOK,   32'h1, "issue3_first");
    expect_val(K_RBUSY, 32'h0, "busy3_before_issue");
    step();
    issue(3);
    rd(3, 0);
    expect_val(K_IOK,   32'h0, "issue3_stall");
    expect_val(K_RBUSY, 32'h1, "busy3_set");
    step();
    issue(3);
    wr(1, 3, 32'h33);
    rd(3, 0);
    expect_val(K_IOK,   32'h1, "issue3_with_write");
    step();
    rd(3, 0);
    expect_val(K_RBUSY, 32'h1, "busy3_set_wins");
    expect_val(K_RDAT0, 32'h33, "reg3_written");
    step();
    wr(0, 3, 32'h34);
    step();
    rd(0, 3);
    expect_val(K_RBUSY, 32'h0, "busy3_cleared");
    expect_val(K_RDAT1, 32'h34, "reg3_rewritten");

    // read during same-cycle write, busy register
    step();
    wr(0, 9, 32'h11);
    issue(9);
    expect_val(K_IOK, 32'h1, "issue9_ok");
    step();
    wr(0, 9, 32'h55);
    rd(9, 9);
`ifdef MULTIPORT_RF_BYPASS_EN
    expect_val(K_RDAT0, 32'h55, "bypass_rdat");
    expect_val(K_RBUSY, 32'h0,  "bypass_rbusy");
`else
    expect_val(K_RDAT0, 32'h11, "nobypass_rdat");
    expect_val(K_RBUSY, 32'h3,  "nobypass_rbusy");
`endif
    step();
    rd(9, 9);
    expect_val(K_RDAT1, 32'h55, "reg9_final");
    expect_val(K_RBUSY, 32'h0,  "busy9_cleared");

    // reset clears everything, ignoring that cycle's writes
    step();
    wr(0, 1, 32'hA);
    wr(1, 2, 32'hB);
    issue(4);
    step();
    RST = 1'b1;
    wr(0, 1, 32'hC);
    wr(1, 2, 32'hD);
    rd(1, 2);
    expect_val(K_RDAT0, 32'hA, "reg1_before_reset");
    expect_val(K_RDAT1, 32'hB, "reg2_before_reset");
    step();
    rd(1, 2);
    expect_val(K_RDAT0, 32'h0, "reg1_after_reset");
    expect_val(K_RDAT1, 32'h0, "reg2_after_reset");
    expect_val(K_RBUSY, 32'h0, "busy12_after_reset");
    step();
    rd(4, 9);
    expect_val(K_RBUSY, 32'h0, "busy4_after_reset");
    expect_val(K_RDAT0, 32'h0, "reg4_after_reset");
    expect_val(K_RDAT1, 32'h0, "reg9_after_reset");

    step();
    step();
    done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    fork
      wait (done);
      #100000;
    join_any
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL timeout: stimulus did not finish, got done=0 expected done=1");
    end else if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
